// File: rtl/move_cmd_queue_if.sv
// Engine-side command handshake of the move command queue.
// The queue drives valid/code/fill; the engine drives ready.
interface move_cmd_queue_if #(
  parameter int DEPTH = 4
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_code;
  logic [$clog2(DEPTH):0]   fill;

  modport master (output cmd_valid, output cmd_code, output fill, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, input fill, output cmd_ready);
endinterface

// File: rtl/move_cmd_queue.sv
// Merges key pulses and a gravity tick, serialises them by priority
// (rot > left > right > down) into a small FIFO feeding the game engine.
module move_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int DROP_MS = 500
) (
  input  logic              clk1k,
  input  logic              rst_n,
  input  logic              k_left,
  input  logic              k_right,
  input  logic              k_rot,
  input  logic              k_down,
  input  logic              drop_en,
  move_cmd_queue_if.master  cmd
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int GW = $clog2(DROP_MS);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill_q;
  logic [3:0]    pend;
  logic [GW-1:0] gcnt;

  logic       tick, push, pop;
  logic [3:0] eff, grant;
  logic [1:0] code;

  assign tick = drop_en && (gcnt == GW'(DROP_MS - 1));
  // bit 3 rot, bit 2 left, bit 1 right, bit 0 down
  assign eff  = pend | {k_rot, k_left, k_right, k_down | tick};
  assign push = (eff != 4'b0) && (fill_q < FW'(DEPTH));
  assign pop  = (fill_q != '0) && cmd.cmd_ready;

  always_comb begin
    grant = 4'b0000;
    code  = 2'b00;
    if (eff[3]) begin
      grant = 4'b1000; code = 2'b10;
    end else if (eff[2]) begin
      grant = 4'b0100; code = 2'b00;
    end else if (eff[1]) begin
      grant = 4'b0010; code = 2'b01;
    end else if (eff[0]) begin
      grant = 4'b0001; code = 2'b11;
    end
  end

  always_ff @(posedge clk1k or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      gcnt   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      // A blocked request stays pending, so nothing is dropped while full.
      pend <= push ? (eff & ~grant) : eff;
      if (!drop_en || k_down || tick) gcnt <= '0;
      else                            gcnt <= gcnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk1k) begin
    if (push) mem[wr_ptr] <= code;
  end

  assign cmd.fill      = fill_q;
  assign cmd.cmd_valid = (fill_q != '0);
  assign cmd.cmd_code  = (fill_q != '0) ? mem[rd_ptr] : 2'b00;
endmodule

// File: tb/tb_move_cmd_queue.sv
// Directed bench for move_cmd_queue (DEPTH=4, DROP_MS=5).
module tb_move_cmd_queue;
  logic clk1k = 1'b0;
  logic rst_n, k_left, k_right, k_rot, k_down, drop_en;
  int checks = 0;
  int errors = 0;

  move_cmd_queue_if #(.DEPTH(4)) cif ();

  move_cmd_queue #(.DEPTH(4), .DROP_MS(5)) dut (
    .clk1k(clk1k), .rst_n(rst_n),
    .k_left(k_left), .k_right(k_right), .k_rot(k_rot), .k_down(k_down),
    .drop_en(drop_en), .cmd(cif)
  );

  always #5 clk1k = ~clk1k;

  task automatic step();
    @(posedge clk1k);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] c, input int f);
    chk({tag, ".valid"}, 32'(cif.cmd_valid), 32'(v));
    chk({tag, ".code"},  32'(cif.cmd_code),  32'(c));
    chk({tag, ".fill"},  32'(cif.fill),      32'(f));
  endtask

  initial begin
    rst_n = 0; k_left = 0; k_right = 0; k_rot = 0; k_down = 0; drop_en = 0;
    cif.cmd_ready = 0;
    step(); step();
    chk_out("reset", 0, 2'b00, 0);
    rst_n = 1;
    step();
    chk_out("post_reset", 0, 2'b00, 0);
    cif.cmd_ready = 1; step(); cif.cmd_ready = 0;
    chk_out("ready_empty", 0, 2'b00, 0);

    // single pulse
    k_left = 1; step(); k_left = 0;
    chk_out("single", 1, 2'b00, 1);
    cif.cmd_ready = 1; step(); cif.cmd_ready = 0;
    chk_out("single_pop", 0, 2'b00, 0);

    // four simultaneous keys enqueue one per edge
    k_left = 1; k_right = 1; k_rot = 1; k_down = 1;
    step();
    k_left = 0; k_right = 0; k_rot = 0; k_down = 0;
    chk("simul.fill1", 32'(cif.fill), 1);
    step(); chk("simul.fill2", 32'(cif.fill), 2);
    step(); chk("simul.fill3", 32'(cif.fill), 3);
    step(); chk_out("simul.fill4", 1, 2'b10, 4);
    cif.cmd_ready = 1;
    step(); chk_out("simul.pop1", 1, 2'b00, 3);
    step(); chk_out("simul.pop2", 1, 2'b01, 2);
    step(); chk_out("simul.pop3", 1, 2'b11, 1);
    step(); chk_out("simul.pop4", 0, 2'b00, 0);
    cif.cmd_ready = 0;

    // full FIFO holds left/right pending
    k_rot = 1; step(); step(); step(); step(); k_rot = 0;
    chk_out("full.rot4", 1, 2'b10, 4);
    k_left = 1; k_right = 1; step(); k_left = 0; k_right = 0;
    chk_out("full.blocked", 1, 2'b10, 4);
    step();
    chk("full.idle", 32'(cif.fill), 4);
    cif.cmd_ready = 1; step(); cif.cmd_ready = 0;
    chk("full.pop_no_push", 32'(cif.fill), 3);
    step(); chk("full.left_in", 32'(cif.fill), 4);
    cif.cmd_ready = 1; step(); cif.cmd_ready = 0;
    chk("full.pop2", 32'(cif.fill), 3);
    step(); chk("full.right_in", 32'(cif.fill), 4);
    step(); chk("full.stable", 32'(cif.fill), 4);
    cif.cmd_ready = 1;
    chk_out("full.drain0", 1, 2'b10, 4);
    step(); chk_out("full.drain1", 1, 2'b10, 3);
    step(); chk_out("full.drain2", 1, 2'b00, 2);
    step(); chk_out("full.drain3", 1, 2'b01, 1);
    step(); chk_out("full.drain4", 0, 2'b00, 0);

    // gravity: ticks at edges 5, 10; k_down at gcnt=3 (edge 14), next tick edge 19
    drop_en = 1;
    for (int i = 1; i <= 13; i++) begin
      step();
      chk($sformatf("grav.e%0d", i), 32'(cif.cmd_valid), 32'((i % 5) == 0));
      if ((i % 5) == 0) chk($sformatf("grav.code%0d", i), 32'(cif.cmd_code), 3);
    end
    k_down = 1; step(); k_down = 0;
    chk_out("grav.kdown", 1, 2'b11, 1);
    for (int i = 15; i <= 19; i++) begin
      step();
      chk($sformatf("grav.e%0d", i), 32'(cif.cmd_valid), 32'(i == 19));
    end
    drop_en = 0;
    step();
    chk_out("grav.off", 0, 2'b00, 0);
    cif.cmd_ready = 0;

    // mid-operation reset with fill=3 and down still pending
    k_left = 1; k_right = 1; k_rot = 1; k_down = 1;
    step();
    k_left = 0; k_right = 0; k_rot = 0; k_down = 0;
    step(); step();
    chk_out("midrst.pre", 1, 2'b10, 3);
    rst_n = 0;
    #1;
    chk_out("midrst.async", 0, 2'b00, 0);
    step();
    rst_n = 1;
    step(); step(); step();
    chk_out("midrst.after", 0, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
